half_adder: RTL and testbench

//  - WIDTH-lane bitwise half adder: per lane sum = a ^ b, carry c = a & b.
//  - Combinational results are available immediately for datapath use.
//  - A registered, valid-qualified copy of the results plus a carry

---
 rtl/half_adder_pkg.sv | 24 ++
 rtl/half_adder_cell.sv | 12 +
 rtl/half_adder.sv | 64 ++++++
 tb/tb_half_adder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared types, widths and helper functions for the half_adder leaf block.
package half_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  // Widest lane vector popcount() accepts; narrower vectors are zero-extended.
  localparam int unsigned POP_MAX_WIDTH = 256;

  // Bits needed to hold a count of 0..width, never less than 1.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = (width < 1) ? 1 : $clog2(width + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(POP_MAX_WIDTH); i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single-bit combinational half adder.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic c
);

  assign sum = a ^ b;
  assign c   = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH-lane half adder with combinational results plus a registered,
// valid-qualified copy and carry popcount. Optional macro: HALF_ADDER_PARITY_EN.
module half_adder
  import half_adder_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] c,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] c_q,
  output logic [CW-1:0]    carry_cnt,
  output logic             parity_q
);

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
    half_adder_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .sum (sum[i]),
      .c   (c[i])
    );
  end

  logic [CW-1:0] carry_cnt_next;
  assign carry_cnt_next = CW'(popcount(POP_MAX_WIDTH'(c)));

  // Result registers only load on in_valid, so idle-cycle operands never reach them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum_q     <= '0;
      c_q       <= '0;
      carry_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q     <= sum;
        c_q       <= c;
        carry_cnt <= carry_cnt_next;
      end
    end
  end

`ifdef HALF_ADDER_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (in_valid) begin
      parity_q <= ^sum;
    end
  end
`else
  assign parity_q = 1'b0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for half_adder at WIDTH=1 and WIDTH=4.
module tb_half_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [0:0] a1, b1, sum1, c1, sum_q1, c_q1, cnt1;
  logic       in_valid1, out_valid1, parity1;

  logic [3:0] a4, b4, sum4, c4, sum_q4, c_q4;
  logic [2:0] cnt4;
  logic       in_valid4, out_valid4, parity4;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HALF_ADDER_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .sum(sum1), .c(c1),
    .in_valid(in_valid1), .out_valid(out_valid1), .sum_q(sum_q1),
    .c_q(c_q1), .carry_cnt(cnt1), .parity_q(parity1)
  );

  half_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .sum(sum4), .c(c4),
    .in_valid(in_valid4), .out_valid(out_valid4), .sum_q(sum_q4),
    .c_q(c_q4), .carry_cnt(cnt4), .parity_q(parity4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs4(input string tag, input logic valid, input logic [3:0] s,
                             input logic [3:0] cq, input logic [2:0] cnt, input logic par);
    check({tag, ".out_valid"}, 32'(out_valid4), 32'(valid));
    check({tag, ".sum_q"},     32'(sum_q4),     32'(s));
    check({tag, ".c_q"},       32'(c_q4),       32'(cq));
    check({tag, ".carry_cnt"}, 32'(cnt4),       32'(cnt));
    check({tag, ".parity_q"},  32'(parity4),    32'(par & PAR_ON));
  endtask

  // Apply operands on the falling edge, then sample just after the next rising edge.
  task automatic cycle4(input logic [3:0] a, input logic [3:0] b, input logic v);
    @(negedge clk);
    a4 = a; b4 = b; in_valid4 = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] ab [4];
    logic [1:0] sc [4];
    ab = '{2'b00, 2'b10, 2'b01, 2'b11};   // {a,b}
    sc = '{2'b00, 2'b10, 2'b10, 2'b01};   // {sum,c}

    a1 = '0; b1 = '0; in_valid1 = 1'b0;
    a4 = '0; b4 = '0; in_valid4 = 1'b0;

    #1 rst = 1'b1;
    #1;
    check_regs4("reset", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
    check("reset.out_valid1", 32'(out_valid1), 32'd0);

    // Combinational truth table, held in reset to show clk/rst do not matter.
    for (int i = 0; i < 4; i++) begin
      a1 = ab[i][1]; b1 = ab[i][0];
      #10;
      check($sformatf("comb1.sum[%0d]", i), 32'(sum1), 32'(sc[i][1]));
      check($sformatf("comb1.c[%0d]", i),   32'(c1),   32'(sc[i][0]));
    end

    @(negedge clk);
    rst = 1'b0;

    cycle4(4'b1010, 4'b0110, 1'b1);
    check("comb4.sum", 32'(sum4), 32'h0000000c);
    check_regs4("cap_a", 1'b1, 4'b1100, 4'b0010, 3'd1, 1'b0);

    cycle4(4'hF, 4'hF, 1'b1);
    check_regs4("cap_all", 1'b1, 4'h0, 4'hF, 3'd4, 1'b0);

    for (int i = 0; i < 3; i++) begin
      cycle4(4'b0101, 4'b0011, 1'b0);
      check_regs4($sformatf("hold%0d", i), 1'b0, 4'h0, 4'hF, 3'd4, 1'b0);
    end

    cycle4(4'b0111, 4'b0000, 1'b1);
    check_regs4("parity", 1'b1, 4'b0111, 4'b0000, 3'd0, 1'b1);

    @(negedge clk);
    in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    a4 = 4'b1100; b4 = 4'b1010; in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    check("cap1.c_q", 32'(c_q1), 32'd1);
    check("cap1.carry_cnt", 32'(cnt1), 32'd1);
    check_regs4("pre_rst", 1'b1, 4'b0110, 4'b1000, 3'd1, 1'b0);

    // Reset between edges clears registers at once; combinational path keeps tracking.
    #2 rst = 1'b1;
    #1;
    check_regs4("mid_rst", 1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
    check("mid_rst.sum", 32'(sum4), 32'h6);
    check("mid_rst.c",   32'(c4),   32'h8);
    check("mid_rst.c_q1", 32'(c_q1), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    a4 = 4'b0011; b4 = 4'b0001; in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    check_regs4("post_rst", 1'b1, 4'b0010, 4'b0001, 3'd1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
